// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Purpose  : Shared IO register map, CTRL bit layout and FSM state encoding.
//  Revision : 1.0
// ============================================================================
package io_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_WINDOW  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_KICKCNT = 2'd3;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_MASK_LSB = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_KICK     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_HALT     = 3'd4
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/wdog_feed_regs.sv
`default_nettype none
// ============================================================================
//  Module   : wdog_feed_regs
//  Purpose  : IO register file of the feed scheduler: CTRL, WINDOW, STATUS,
//             KICKCNT, read mux and the sticky miss set/clear logic.
//  Revision : 1.0
// ============================================================================
module wdog_feed_regs
    import io_pkg::*;
#(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] WIN_RST = 16'h4000
) (
    input  logic             clk,
    input  logic             w_reset,
    input  logic             io_cs,
    input  logic             io_we,
    input  logic [1:0]       io_addr,
    input  logic [15:0]      io_wdata,
    output logic [15:0]      io_rdata,
    input  logic [N_REQ-1:0] i_seen,
    input  logic             i_miss_set,
    input  logic [N_REQ-1:0] i_miss_bits_set,
    input  logic             i_kick,
    output logic             o_run,
    output logic             o_run_clr,
    output logic [N_REQ-1:0] o_mask,
    output logic [15:0]      o_window,
    output logic             o_miss
);

    logic             r_run;
    logic [N_REQ-1:0] r_mask;
    logic [15:0]      r_window;
    logic [N_REQ-1:0] r_miss_bits;
    logic             r_miss;
    logic [15:0]      r_kickcnt;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_win;
    logic        w_stat_clr;
    logic        w_wr_kc;
    logic [15:0] w_rdata;

    assign w_wr       = io_cs & io_we;
    assign w_wr_ctrl  = w_wr && (io_addr == ADDR_CTRL);
    assign w_wr_win   = w_wr && (io_addr == ADDR_WINDOW);
    assign w_stat_clr = w_wr && (io_addr == ADDR_STATUS) && io_wdata[15];
    assign w_wr_kc    = w_wr && (io_addr == ADDR_KICKCNT);

    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_run       <= 1'b0;
            r_mask      <= '0;
            r_window    <= WIN_RST;
            r_miss_bits <= '0;
            r_miss      <= 1'b0;
            r_kickcnt   <= 16'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_run  <= io_wdata[CTRL_RUN_BIT];
                r_mask <= io_wdata[CTRL_MASK_LSB +: N_REQ];
            end
            if (w_wr_win) begin
                r_window <= io_wdata;
            end
            // A miss detected in the same cycle as a CPU clear survives it
            r_miss_bits <= (w_stat_clr ? '0 : r_miss_bits) | i_miss_bits_set;
            r_miss      <= (w_stat_clr ? 1'b0 : r_miss) | i_miss_set;
            if (w_wr_kc) begin
                r_kickcnt <= 16'd0;
            end else if (i_kick) begin
                r_kickcnt <= r_kickcnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = 16'd0;
        if (io_cs) begin
            case (io_addr)
                ADDR_CTRL: begin
                    w_rdata[CTRL_RUN_BIT]            = r_run;
                    w_rdata[CTRL_MASK_LSB +: N_REQ]  = r_mask;
                end
                ADDR_WINDOW: w_rdata = r_window;
                ADDR_STATUS: begin
                    w_rdata[N_REQ-1:0]      = i_seen;
                    w_rdata[N_REQ +: N_REQ] = r_miss_bits;
                    w_rdata[15]             = r_miss;
                end
                default: w_rdata = r_kickcnt;
            endcase
        end
    end

    assign io_rdata  = w_rdata;
    assign o_run     = r_run;
    assign o_run_clr = w_wr_ctrl & ~io_wdata[CTRL_RUN_BIT];
    assign o_mask    = r_mask;
    assign o_window  = r_window;
    assign o_miss    = r_miss;

endmodule
`default_nettype wire

// File: rtl/wdog_feed_sched.sv
`default_nettype none
// ============================================================================
//  Module   : wdog_feed_sched
//  Purpose  : Kicks the watchdog only once every enabled requester has
//             checked in within the current window; a miss halts kicking.
//  Revision : 1.0
// ============================================================================
module wdog_feed_sched
    import io_pkg::*;
#(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] WIN_RST = 16'h4000,
    parameter int          MIN_GAP = 8
) (
    input  logic             clk,
    input  logic             w_reset,
    input  logic [N_REQ-1:0] req_alive,
    input  logic             io_cs,
    input  logic             io_we,
    input  logic [1:0]       io_addr,
    input  logic [15:0]      io_wdata,
    output logic [15:0]      io_rdata,
    output logic             wd_cs,
    output logic             wd_w,
    output logic             miss
);

    localparam int               GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;
    logic [N_REQ-1:0] r_seen;
    logic [N_REQ-1:0] w_seen_next;
    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_miss_bits_set;
    logic [15:0]      r_win_ct;
    logic [15:0]      w_window;
    logic [15:0]      w_reload;
    logic [GAP_W-1:0] r_gap_ct;
    logic             w_run;
    logic             w_run_clr;
    logic             w_complete;
    logic             w_win_zero;
    logic             w_gap_zero;
    logic             w_kick;
    logic             w_miss_set;

    wdog_feed_regs #(
        .N_REQ   (N_REQ),
        .WIN_RST (WIN_RST)
    ) u_regs (
        .clk             (clk),
        .w_reset         (w_reset),
        .io_cs           (io_cs),
        .io_we           (io_we),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_rdata        (io_rdata),
        .i_seen          (r_seen),
        .i_miss_set      (w_miss_set),
        .i_miss_bits_set (w_miss_bits_set),
        .i_kick          (w_kick),
        .o_run           (w_run),
        .o_run_clr       (w_run_clr),
        .o_mask          (w_mask),
        .o_window        (w_window),
        .o_miss          (miss)
    );

    // Same-cycle pulses count toward completion
    assign w_seen_next = r_seen | (req_alive & w_mask);
    assign w_complete  = ((w_seen_next & w_mask) == w_mask);
    assign w_win_zero  = (r_win_ct == 16'd0);
    assign w_gap_zero  = (r_gap_ct == '0);
    assign w_reload    = (w_window == 16'd0) ? 16'd1 : w_window;

    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run && (w_mask != '0)) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_complete)      w_state_next = ST_KICK;
                else if (w_win_zero) w_state_next = ST_HALT;
            end
            ST_KICK: w_state_next = ST_COOLDOWN;
            ST_COOLDOWN: begin
                if (w_gap_zero) begin
                    if (w_complete)      w_state_next = ST_KICK;
                    else if (w_win_zero) w_state_next = ST_HALT;
                    else                 w_state_next = ST_COLLECT;
                end else if (w_win_zero && !w_complete) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_run_clr) w_state_next = ST_IDLE;
    end

    always_comb begin
        w_kick          = (r_state == ST_KICK);
        w_miss_set      = 1'b0;
        w_miss_bits_set = '0;
        if ((w_state_next == ST_HALT) && (r_state != ST_HALT)) begin
            w_miss_set      = 1'b1;
            w_miss_bits_set = w_mask & ~w_seen_next;
        end
    end

    assign wd_cs = w_kick;
    assign wd_w  = w_kick;

    // Window counter saturates at zero so an expiry inside cooldown stays pending
    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_seen   <= '0;
            r_win_ct <= 16'd0;
            r_gap_ct <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_seen <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_seen   <= '0;
                    r_win_ct <= w_reload;
                end
                ST_COLLECT: begin
                    r_seen <= w_seen_next;
                    if (!w_win_zero) r_win_ct <= r_win_ct - 16'd1;
                end
                ST_KICK: begin
                    r_seen   <= '0;
                    r_win_ct <= w_reload;
                    r_gap_ct <= GAP_LOAD;
                end
                ST_COOLDOWN: begin
                    r_seen <= w_seen_next;
                    if (!w_win_zero) r_win_ct <= r_win_ct - 16'd1;
                    if (!w_gap_zero) r_gap_ct <= r_gap_ct - GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wdog_feed_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wdog_feed_sched
//  Purpose  : Self-checking bench for wdog_feed_sched against a deadline-based
//             reference model of the feed rules.
//  Revision : 1.0
// ============================================================================
module tb_wdog_feed_sched;

    localparam int          N_REQ   = 4;
    localparam logic [15:0] WIN_RST = 16'h4000;
    localparam int          MIN_GAP = 8;

    localparam int PH_IDLE   = 0;
    localparam int PH_ACTIVE = 1;
    localparam int PH_KICK   = 2;
    localparam int PH_HALT   = 3;

    logic             clk = 1'b0;
    logic             w_reset;
    logic [N_REQ-1:0] req_alive;
    logic             io_cs;
    logic             io_we;
    logic [1:0]       io_addr;
    logic [15:0]      io_wdata;
    logic [15:0]      io_rdata;
    logic             wd_cs;
    logic             wd_w;
    logic             miss;

    always #5 clk = ~clk;

    wdog_feed_sched #(
        .N_REQ   (N_REQ),
        .WIN_RST (WIN_RST),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk       (clk),
        .w_reset   (w_reset),
        .req_alive (req_alive),
        .io_cs     (io_cs),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .wd_cs     (wd_cs),
        .wd_w      (wd_w),
        .miss      (miss)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: absolute-time deadlines rather than down-counters
    int          m_t = 0;
    int          m_phase;
    int          m_deadline;
    int          m_gap_ok;
    logic        m_run;
    logic [3:0]  m_mask;
    logic [15:0] m_window;
    logic [3:0]  m_seen;
    logic [3:0]  m_missb;
    logic        m_miss;
    logic [15:0] m_kc;

    logic [18:0] obs_v, exp_v;
    logic        obs_cs, obs_miss;
    logic [15:0] obs_rd;

    function automatic logic [15:0] m_read(input logic [1:0] a);
        logic [15:0] r;
        r = 16'd0;
        case (a)
            2'd0:    r = {11'd0, m_mask, m_run};
            2'd1:    r = m_window;
            2'd2:    r = {m_miss, 7'd0, m_missb, m_seen};
            default: r = m_kc;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_run = 1'b0; m_mask = 4'd0; m_window = WIN_RST;
        m_seen = 4'd0; m_missb = 4'd0; m_miss = 1'b0; m_kc = 16'd0;
        m_deadline = 0; m_gap_ok = 0;
    endtask

    task automatic model_step();
        logic [3:0] seen_n;
        logic       complete;
        logic [3:0] set_bits;
        logic       set_miss;
        logic       bus_wr;
        int         nph;
        int         wlen;
        wlen     = (m_window == 16'd0) ? 1 : int'(m_window);
        set_bits = 4'd0;
        set_miss = 1'b0;
        nph      = m_phase;
        bus_wr   = io_cs && io_we;
        case (m_phase)
            PH_IDLE: begin
                m_seen = 4'd0;
                if (m_run && m_mask != 4'd0) begin
                    nph = PH_ACTIVE; m_deadline = m_t + 1 + wlen; m_gap_ok = m_t + 1;
                end
            end
            PH_ACTIVE: begin
                seen_n   = m_seen | (req_alive & m_mask);
                complete = ((seen_n & m_mask) == m_mask);
                if (complete && m_t >= m_gap_ok) nph = PH_KICK;
                else if (!complete && m_t >= m_deadline) begin
                    nph = PH_HALT; set_bits = m_mask & ~seen_n; set_miss = 1'b1;
                end
                m_seen = seen_n;
            end
            PH_KICK: begin
                m_seen = 4'd0; nph = PH_ACTIVE;
                m_deadline = m_t + 1 + wlen; m_gap_ok = m_t + MIN_GAP;
            end
            default: begin
            end
        endcase
        if (bus_wr && io_addr == 2'd0 && !io_wdata[0]) begin
            nph = PH_IDLE; m_seen = 4'd0; set_bits = 4'd0; set_miss = 1'b0;
        end
        if (bus_wr && io_addr == 2'd3) m_kc = 16'd0;
        else if (m_phase == PH_KICK)   m_kc = m_kc + 16'd1;
        if (bus_wr && io_addr == 2'd2 && io_wdata[15]) begin
            m_missb = 4'd0; m_miss = 1'b0;
        end
        m_missb = m_missb | set_bits;
        m_miss  = m_miss | set_miss;
        if (bus_wr && io_addr == 2'd0) begin
            m_run = io_wdata[0]; m_mask = io_wdata[4:1];
        end
        if (bus_wr && io_addr == 2'd1) m_window = io_wdata;
        m_phase = nph;
    endtask

    // One clock: sample DUT and model on the falling edge, then advance
    task automatic tick();
        @(negedge clk);
        obs_cs   = wd_cs;
        obs_miss = miss;
        obs_rd   = io_rdata;
        obs_v    = {wd_cs, wd_w, miss, io_rdata};
        exp_v    = {m_phase == PH_KICK, m_phase == PH_KICK, m_miss,
                    io_cs ? m_read(io_addr) : 16'h0000};
        if (w_reset) model_reset();
        else         model_step();
        m_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        io_cs = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
        tick();
        io_cs = 1'b0; io_we = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a);
        io_cs = 1'b1; io_we = 1'b0; io_addr = a;
        tick();
        io_cs = 1'b0;
    endtask

    task automatic do_reset();
        w_reset = 1'b1; req_alive = '0; io_cs = 1'b0; io_we = 1'b0;
        tick();
        tick();
        w_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_vals [4];
        exp_vals = '{16'h0000, WIN_RST, 16'h0000, 16'h0000};
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a));
            n_checks++;
            if (obs_rd !== exp_vals[a] || obs_cs !== 1'b0 || obs_miss !== 1'b0)
                $display("FAIL reset_reg%0d: got rd=%h cs=%b miss=%b expected rd=%h cs=0 miss=0",
                         a, obs_rd, obs_cs, obs_miss, exp_vals[a]);
            else n_pass++;
        end
    endtask

    task automatic test_basic_kick();
        int kick_at;
        int kicks;
        kick_at = -1; kicks = 0;
        do_reset();
        wr_reg(2'd1, 16'd100);
        wr_reg(2'd0, 16'h001F);
        for (int i = 1; i <= 60; i++) begin
            case (i)
                10:      req_alive = 4'b0001;
                20:      req_alive = 4'b0010;
                30:      req_alive = 4'b0100;
                40:      req_alive = 4'b1000;
                default: req_alive = 4'b0000;
            endcase
            tick();
            req_alive = '0;
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL basic_cyc%0d: got %h expected %h", i, obs_v, exp_v);
            else n_pass++;
            if (obs_cs === 1'b1) begin
                kicks++;
                if (kick_at < 0) kick_at = i;
            end
        end
        n_checks++;
        if (kick_at != 41 || kicks != 1)
            $display("FAIL basic_latency: got first kick %0d count %0d expected 41 and 1", kick_at, kicks);
        else n_pass++;
        rd_reg(2'd3);
        n_checks++;
        if (obs_rd !== 16'd1) $display("FAIL basic_kickcnt: got %h expected 0001", obs_rd);
        else n_pass++;
        rd_reg(2'd2);
        n_checks++;
        if (obs_rd !== 16'h0000) $display("FAIL basic_status: got %h expected 0000", obs_rd);
        else n_pass++;
    endtask

    task automatic test_miss();
        int kicks;
        kicks = 0;
        do_reset();
        wr_reg(2'd1, 16'd100);
        wr_reg(2'd0, 16'h001F);
        for (int i = 1; i <= 130; i++) begin
            case (i)
                10:      req_alive = 4'b0001;
                20:      req_alive = 4'b0010;
                30:      req_alive = 4'b1000;
                default: req_alive = 4'b0000;
            endcase
            tick();
            req_alive = '0;
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL miss_cyc%0d: got %h expected %h", i, obs_v, exp_v);
            else n_pass++;
            if (obs_cs === 1'b1) kicks++;
        end
        n_checks++;
        if (kicks != 0 || obs_miss !== 1'b1)
            $display("FAIL miss_halt: got kicks=%0d miss=%b expected kicks=0 miss=1", kicks, obs_miss);
        else n_pass++;
        rd_reg(2'd2);
        n_checks++;
        if (obs_rd !== 16'h804B) $display("FAIL miss_status: got %h expected 804b", obs_rd);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        wr_reg(2'd1, 16'd20);
        wr_reg(2'd0, 16'h001F);
        for (int i = 1; i <= 40; i++) begin
            req_alive = (i == 22) ? 4'hF : 4'h0;
            tick();
            req_alive = '0;
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL prio_cyc%0d: got %h expected %h", i, obs_v, exp_v);
            else n_pass++;
            if (i == 23) begin
                n_checks++;
                if (obs_cs !== 1'b1) $display("FAIL prio_kick: got wd_cs=%b expected 1", obs_cs);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_miss !== 1'b0) $display("FAIL prio_miss: got %b expected 0", obs_miss);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int kicks[$];
        do_reset();
        wr_reg(2'd1, 16'd100);
        wr_reg(2'd0, 16'h001F);
        req_alive = 4'hF;
        io_cs = 1'b1; io_we = 1'b0; io_addr = 2'd3;
        for (int i = 1; i <= 60; i++) begin
            tick();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL b2b_cyc%0d: got %h expected %h", i, obs_v, exp_v);
            else n_pass++;
            if (obs_cs === 1'b1) kicks.push_back(i);
        end
        io_cs = 1'b0;
        req_alive = '0;
        n_checks++;
        if (kicks.size() != 7 || kicks[0] != 3)
            $display("FAIL b2b_count: got %0d kicks expected 7 starting at cycle 3", kicks.size());
        else n_pass++;
        for (int k = 1; k < kicks.size(); k++) begin
            n_checks++;
            if (kicks[k] - kicks[k-1] != 9)
                $display("FAIL b2b_period%0d: got %0d expected 9", k, kicks[k] - kicks[k-1]);
            else n_pass++;
        end
        rd_reg(2'd3);
        n_checks++;
        if (obs_rd !== 16'd7) $display("FAIL b2b_kickcnt: got %h expected 0007", obs_rd);
        else n_pass++;
    endtask

    task automatic test_stop_and_reset();
        int kicks;
        logic [15:0] exp_vals [4];
        kicks = 0;
        exp_vals = '{16'h0000, WIN_RST, 16'h0000, 16'h0000};
        do_reset();
        wr_reg(2'd1, 16'd50);
        wr_reg(2'd0, 16'h001F);
        for (int i = 1; i <= 5; i++) tick();
        wr_reg(2'd0, 16'h0000);
        req_alive = 4'hF;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs_cs === 1'b1) kicks++;
        end
        req_alive = '0;
        n_checks++;
        if (kicks != 0) $display("FAIL stop_nokick: got %0d kicks expected 0", kicks);
        else n_pass++;
        rd_reg(2'd2);
        n_checks++;
        if (obs_rd !== 16'h0000) $display("FAIL stop_status: got %h expected 0000", obs_rd);
        else n_pass++;
        wr_reg(2'd1, 16'd5);
        wr_reg(2'd0, 16'h001F);
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (obs_miss !== 1'b1) $display("FAIL halt_miss: got %b expected 1", obs_miss);
        else n_pass++;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a));
            n_checks++;
            if (obs_rd !== exp_vals[a] || obs_miss !== 1'b0)
                $display("FAIL halt_reset_reg%0d: got rd=%h miss=%b expected rd=%h miss=0",
                         a, obs_rd, obs_miss, exp_vals[a]);
            else n_pass++;
        end
    endtask

    task automatic test_status_race();
        do_reset();
        wr_reg(2'd1, 16'd20);
        wr_reg(2'd0, 16'h001F);
        for (int i = 1; i <= 21; i++) tick();
        wr_reg(2'd2, 16'h8000);
        rd_reg(2'd2);
        n_checks++;
        if (obs_rd !== 16'h80F0 || obs_miss !== 1'b1)
            $display("FAIL race_setwins: got status=%h miss=%b expected 80f0 and 1", obs_rd, obs_miss);
        else n_pass++;
        wr_reg(2'd2, 16'h8000);
        rd_reg(2'd2);
        n_checks++;
        if (obs_rd !== 16'h0000 || obs_miss !== 1'b0)
            $display("FAIL race_clear: got status=%h miss=%b expected 0000 and 0", obs_rd, obs_miss);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        wr_reg(2'd1, 16'd30);
        wr_reg(2'd0, 16'h001F);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N_REQ; b++) req_alive[b] = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 99);
            io_cs = 1'b0; io_we = 1'b0; io_addr = 2'($urandom_range(0, 3));
            io_wdata = 16'($urandom);
            if (r < 3) begin
                io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd0; io_wdata[0] = 1'b1;
            end else if (r < 5) begin
                io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd0; io_wdata[0] = 1'b0;
            end else if (r < 8) begin
                io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd1; io_wdata = 16'($urandom_range(0, 60));
            end else if (r < 10) begin
                io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd2;
            end else if (r < 11) begin
                io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd3;
            end else if (r < 14) begin
                io_we = 1'b1;
            end else if (r < 60) begin
                io_cs = 1'b1;
            end
            tick();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL rand_cyc%0d: got %h expected %h", i, obs_v, exp_v);
            else n_pass++;
        end
        io_cs = 1'b0; io_we = 1'b0; req_alive = '0;
    endtask

    initial begin
        w_reset = 1'b1; req_alive = '0; io_cs = 1'b0; io_we = 1'b0;
        io_addr = 2'd0; io_wdata = 16'd0;
        model_reset();
        test_reset();
        test_basic_kick();
        test_miss();
        test_priority();
        test_back_to_back();
        test_stop_and_reset();
        test_status_race();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
